instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC sequencing, synchronous instruction memory and a 2-entry decoder FIFO.
// Optional feature: define IFETCH_EBREAK_HALT_EN to stop fetch when EBREAK is captured.
module instruction_fetch #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    input  logic                          redirect_valid,
    input  logic [63:0]                   redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_inst,
    output logic [63:0]                   out_pc,
    output logic                          halted
);
    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic [31:0] mem [IMEM_DEPTH];

    logic [63:0] redirect_pc_al;
    logic [63:0] issue_pc_p0;
    logic        issue_p0;

    logic [31:0] inst_p1;
    logic [63:0] pc_p1;
    logic        vld_p1;

    logic [31:0] fifo_inst [2];
    logic [63:0] fifo_pc   [2];
    logic [1:0]  count;
    logic        wr_slot;
    logic        pop;
    logic        capture;
    logic        ebreak_cap;
    logic [2:0]  occ;
    logic        unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_pc_al      = {redirect_pc[63:2], 2'b00};

    // A redirect issues its own target in the redirect cycle, replacing the sequential PC.
    assign issue_pc_p0 = redirect_valid ? redirect_pc_al : pc;

    assign pop     = out_valid & out_ready;
    assign capture = vld_p1 & ~redirect_valid;
    // Occupancy as it will stand after this cycle's pop, so a draining FIFO keeps 1/cycle.
    assign occ     = {1'b0, count} - {2'b00, pop} + {2'b00, vld_p1};
    assign wr_slot = (count > {1'b0, pop});

`ifdef IFETCH_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK = 32'h00100073;
    assign ebreak_cap = vld_p1 && (inst_p1 == EBREAK);
    assign halted     = (state == HALT);
`else
    assign ebreak_cap = 1'b0;
    assign halted     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        issue_p0  = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (redirect_valid) begin
                    issue_p0 = 1'b1;
                end else if (ebreak_cap) begin
                    state_nxt = HALT;
                end else begin
                    issue_p0 = (occ < 3'd2);
                end
            end
            HALT: if (redirect_valid) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= BOOT;
            pc     <= RESET_PC;
            vld_p1 <= 1'b0;
            count  <= 2'd0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= issue_p0;
            if (issue_p0) begin
                pc <= issue_pc_p0 + 64'd4;
            end else if (redirect_valid) begin
                pc <= redirect_pc_al;
            end
            if (redirect_valid) begin
                count <= 2'd0;
            end else begin
                count <= count - {1'b0, pop} + {1'b0, capture};
            end
        end
    end

    // ---- stage p0 -> p1: memory read (old data on a same-address write)
    always_ff @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
        inst_p1 <= mem[issue_pc_p0[AW+1:2]];
        pc_p1   <= issue_pc_p0;
    end

    // ---- stage p1 -> FIFO: slot 0 is always the head
    always_ff @(posedge clk) begin
        if (pop) begin
            fifo_inst[0] <= fifo_inst[1];
            fifo_pc[0]   <= fifo_pc[1];
        end
        if (capture) begin
            fifo_inst[wr_slot] <= inst_p1;
            fifo_pc[wr_slot]   <= pc_p1;
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_inst  = out_valid ? fifo_inst[0] : 32'd0;
    assign out_pc    = out_valid ? fifo_pc[0]   : 64'd0;

endmodule
